// File: rtl/trigger_network_sync.sv
// trigger_network_sync
//   Network-level controller for an array of per-actor trigger FSMs.
//   Aggregates per-trigger status into registered all_* qualifiers, runs the
//   host ap_start/ap_done handshake, and counts synchronisation rounds.
// Ports:
//   ap_clk, ap_rst          clock, async active-high reset
//   ap_start                host start request (level)
//   ap_done/ap_ready        one-cycle completion pulse (identical)
//   ap_idle                 controller is idle
//   trig_sleep/sync_exec/
//   trig_sync_wait/idle     per-trigger status, NUM_ACTORS bits each
//   trig_start              one-cycle launch broadcast to all triggers
//   all_sleep/all_sync/
//   all_sync_wait           registered AND-reductions of trigger status
//   sync_rounds/exec_rounds round counters for the current/last run
module trigger_network_sync #(
  parameter int NUM_ACTORS   = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  input  logic [NUM_ACTORS-1:0] trig_sleep,
  input  logic [NUM_ACTORS-1:0] trig_sync_exec,
  input  logic [NUM_ACTORS-1:0] trig_sync_wait,
  input  logic [NUM_ACTORS-1:0] trig_idle,
  output logic                  trig_start,
  output logic                  all_sleep,
  output logic                  all_sync,
  output logic                  all_sync_wait,
  output logic [31:0]           sync_rounds,
  output logic [31:0]           exec_rounds
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [31:0]   sync_rounds_q, sync_rounds_d;
  logic [31:0]   exec_rounds_q, exec_rounds_d;
  logic          all_sleep_q;
  logic          all_sync_q;
  logic          all_sync_wait_q;
  logic          all_idle_q;
  logic          all_sync_prev_q;
  logic          round_edge;

  // A round is the rising edge of the registered all_sync qualifier.
  assign round_edge = all_sync_q & ~all_sync_prev_q;

  always_comb begin
    state_d       = state_q;
    guard_d       = guard_q;
    sync_rounds_d = sync_rounds_q;
    exec_rounds_d = exec_rounds_q;
    case (state_q)
      IDLE: begin
        if (ap_start) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d       = RUN;
        sync_rounds_d = '0;
        exec_rounds_d = '0;
        guard_d       = GW'(GUARD_CYCLES);
      end
      RUN: begin
        if (guard_q != '0) guard_d = guard_q - 1'b1;
        if (guard_q == '0 && all_idle_q) state_d = DONE;
        if (round_edge) begin
          sync_rounds_d = sync_rounds_q + 32'd1;
          if (!all_sync_wait_q) exec_rounds_d = exec_rounds_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q         <= IDLE;
      guard_q         <= '0;
      sync_rounds_q   <= '0;
      exec_rounds_q   <= '0;
      all_sleep_q     <= 1'b0;
      all_sync_q      <= 1'b0;
      all_sync_wait_q <= 1'b0;
      all_idle_q      <= 1'b0;
      all_sync_prev_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      guard_q         <= guard_d;
      sync_rounds_q   <= sync_rounds_d;
      exec_rounds_q   <= exec_rounds_d;
      all_sleep_q     <= &trig_sleep;
      all_sync_q      <= &(trig_sync_exec | trig_sync_wait);
      all_sync_wait_q <= &trig_sync_wait;
      all_idle_q      <= &trig_idle;
      all_sync_prev_q <= all_sync_q;
    end
  end

  assign ap_idle       = (state_q == IDLE);
  assign trig_start    = (state_q == LAUNCH);
  assign ap_done       = (state_q == DONE);
  assign ap_ready      = (state_q == DONE);
  assign all_sleep     = all_sleep_q;
  assign all_sync      = all_sync_q;
  assign all_sync_wait = all_sync_wait_q;
  assign sync_rounds   = sync_rounds_q;
  assign exec_rounds   = exec_rounds_q;

endmodule
